hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. It works alongside the operand-forwarding logic and covers the hazards forwarding cannot resolve:
- load-use hazards: inserts a one-cycle bubble;
- taken branches: flushes IF/ID and ID/EX;
- multi-cycle data-memory accesses: freezes the whole pipeline until the memory handshake completes.

It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug readout.

Parameters:
CNT_W, 16, width of the stall-cycle performance counter
TO_W, 8, width of the memory-wait timeout counter
MEM_TIMEOUT, 200, wait cycles after which mem_timeout is set (must be < 2^TO_W)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
rs1_id  in  5  rs1 of instruction in ID
rs2_id  in  5  rs2 of instruction in ID
rs1_used  in  1  ID instruction reads rs1
rs2_used  in  1  ID instruction reads rs2
rd_ex  in  5  rd of instruction in EX
mem_read_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  EX resolved a taken branch/jump
mem_req  in  1  MEM stage is issuing a data-memory access this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID load NOP
id_ex_flush  out  1  ID/EX load bubble (controls cleared)
ex_mem_write  out  1  EX/MEM register enable
mem_wb_write  out  1  MEM/WB register enable
mem_wait  out  1  controller in MEM_WAIT state
mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
Interface:
- Single clock clk.
- Reset rst_n is asynchronous and active-low.

State machine (registered state, 2 states):
- RUN.
- MEM_WAIT.
- RUN -> MEM_WAIT when mem_req=1 and mem_ready=0.
- MEM_WAIT -> RUN in the cycle mem_ready=1.
- A mem_req with mem_ready=1 in the same cycle completes in RUN with no stall.

Control outputs are combinational from state and inputs. Priority, highest first:
1. Memory freeze: (state=MEM_WAIT and mem_ready=0), or (state=RUN and mem_req=1 and mem_ready=0).
   - pc_write, if_id_write, ex_mem_write, mem_wb_write = 0.
   - No flushes.
   - branch_taken_ex and load-use are ignored. EX is frozen, so they re-present after release.
   - mem_wb_write=0 while frozen. WB of the instruction ahead still completes because the register file writes from the MEM/WB contents.
2. Branch flush (branch_taken_ex=1):
   - if_id_flush=1, id_ex_flush=1, all writes=1.
   - Any load-use hazard is suppressed, since the ID instruction is being squashed.
3. Load-use, where hazard = mem_read_ex and rd_ex!=0 and ((rs1_used and rs1_id==rd_ex) or (rs2_used and rs2_id==rd_ex)):
   - pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1.
   - Exactly one bubble. Next cycle the load is in MEM and forwarding resolves the dependency.
4. Otherwise: all writes=1, no flushes.

In the cycle mem_ready=1 during MEM_WAIT, the freeze releases combinationally: all writes=1 and priorities 2–3 apply normally.

mem_wait = (state==MEM_WAIT).

Timeout counter:
- Clears on entry to MEM_WAIT; increments each MEM_WAIT cycle; saturates at 2^TO_W-1.
- When the count reaches MEM_TIMEOUT, mem_timeout is set. It stays set until reset.
- The wait continues regardless; the timeout is not an abort.

stall_cycles:
- Increments on every clock edge where pc_write=0.
- Saturates at all-ones and never wraps.

Reset, applied asynchronously at any time including mid-MEM_WAIT:
- state=RUN, timeout counter=0, mem_timeout=0, stall_cycles=0.
- While rst_n=0 the outputs take their RUN values with inputs as presented.
- The core holds mem_req=0 and branch_taken_ex=0 during reset, giving pc_write=1 and no flushes.

No latency beyond the combinational path; registered outputs update on the rising clk edge.

Test Plan:
1. Load-use:
   - Stimulus: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used=1 for one cycle, then mem_read_ex=0.
   - Required: that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all writes=1; stall_cycles=1.
   - Repeat with rd_ex=0, and with rs1_used=0 (rs1_id still matching): no stall.
2. Branch plus load-use, same cycle:
   - Stimulus: branch_taken_ex=1 with the load-use condition true.
   - Required: if_id_flush=1, id_ex_flush=1, pc_write=1; stall_cycles unchanged.
3. Memory wait:
   - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
   - Required: all writes=0 for 3 cycles, mem_wait=1 on cycles 2–3, release in cycle 4, state=RUN after; stall_cycles=3.
   - Same-cycle mem_ready=1: no stall.
4. Memory wait plus branch:
   - Stimulus: branch_taken_ex=1 held through a 2-cycle wait.
   - Required: no flush while frozen; flush asserted exactly in the release cycle.
5. Timeout:
   - Stimulus: MEM_TIMEOUT=4; hold mem_ready=0 for 6 cycles.
   - Required: mem_timeout rises after 4 MEM_WAIT cycles and remains 1 after mem_ready=1 until rst_n=0.
6. Reset mid-wait and counter saturation:
   - Stimulus: assert rst_n=0 asynchronously during MEM_WAIT.
   - Required: immediately mem_wait=0, stall_cycles=0, mem_timeout=0.
   - With CNT_W=4 and 20 stall cycles: stall_cycles=15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage RV32 core: load-use bubbles,
// taken-branch flushes, memory-wait freezes, plus debug stall/timeout counters.
module hazard_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [TO_W-1:0]  TO_MAX   = {TO_W{1'b1}};
  localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic [TO_W-1:0]  to_inc_s;
  logic             mem_timeout_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             freeze_s;
  logic             load_use_s;

  // Load-use hazard detection; x0 never carries a real dependency.
  always_comb begin
    load_use_s = 1'b0;
    if (mem_read_ex && (rd_ex != 5'd0)) begin
      load_use_s = (rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state logic and prioritised pipeline control.
  always_comb begin
    state_nxt_s  = state_r;
    freeze_s     = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;

    case (state_r)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_s    = 1'b1;
          state_nxt_s = ST_MEM_WAIT;
        end else begin
          freeze_s    = 1'b0;
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          freeze_s    = 1'b0;
          state_nxt_s = ST_RUN;
        end else begin
          freeze_s    = 1'b1;
          state_nxt_s = ST_MEM_WAIT;
        end
      end
      default: begin
        freeze_s    = 1'b0;
        state_nxt_s = ST_RUN;
      end
    endcase

    // EX is held during a freeze, so branch and load-use re-present on release.
    if (freeze_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end else begin
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign to_inc_s = (to_cnt_r == TO_MAX) ? to_cnt_r : (to_cnt_r + TO_ONE);

  // Memory-wait timeout counter and sticky flag; a timeout never aborts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r      <= {TO_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else if (state_r == ST_MEM_WAIT) begin
      to_cnt_r <= to_inc_s;
      if (to_inc_s >= TO_LIMIT) begin
        mem_timeout_r <= 1'b1;
      end else begin
        mem_timeout_r <= mem_timeout_r;
      end
    end else if (state_nxt_s == ST_MEM_WAIT) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign mem_wait     = (state_r == ST_MEM_WAIT);
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_hazard_stall_controller;

  localparam int CNT_W       = 4;
  localparam int TO_W        = 8;
  localparam int MEM_TIMEOUT = 4;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic rs1_used, rs2_used, mem_read_ex, branch_taken_ex, mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write;
  logic mem_wait, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [5:0] ctrl;

  int total = 0;
  int bad = 0;

  // Reference model state: plain integers, not the RTL encoding.
  bit m_wait;
  int m_wait_len;
  bit m_to;
  int m_stall;

  hazard_stall_controller #(.CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .mem_wait(mem_wait), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write};

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write}.
  function automatic logic [5:0] exp_ctrl();
    bit frz, lu;
    frz = m_wait ? !mem_ready : (mem_req && !mem_ready);
    lu  = mem_read_ex && (rd_ex != 5'd0) &&
          ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));
    if (frz)                  return 6'b000000;
    else if (branch_taken_ex) return 6'b111111;
    else if (lu)              return 6'b000111;
    else                      return 6'b110011;
  endfunction

  task automatic model_reset();
    m_wait = 1'b0; m_wait_len = 0; m_to = 1'b0; m_stall = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs presented.
  task automatic tick();
    logic [5:0] e;
    e = exp_ctrl();
    @(posedge clk);
    if (rst_n) begin
      if (!e[5] && m_stall < STALL_MAX) m_stall++;
      if (m_wait) begin
        if (m_wait_len < 255) m_wait_len++;
        if (m_wait_len >= MEM_TIMEOUT) m_to = 1'b1;
        if (mem_ready) m_wait = 1'b0;
      end else if (mem_req && !mem_ready) begin
        m_wait = 1'b1;
        m_wait_len = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; mem_read_ex = 1'b0;
    branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
    mem_read_ex = 1'b1; rd_ex = rd; rs1_id = rs1; rs1_used = use1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    model_reset();
    #3;
    total++;
    if (ctrl !== 6'b110011 || mem_wait !== 1'b0 || mem_timeout !== 1'b0 || stall_cycles !== '0) begin
      $display("FAIL reset ctrl=%b wait=%b to=%b stall=%0d want ctrl=110011 wait=0 to=0 stall=0",
               ctrl, mem_wait, mem_timeout, stall_cycles);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd5, 5'd5, 1'b1);
    #1; total++;
    if (ctrl !== 6'b000111) begin $display("FAIL lu_stall ctrl=%b want=000111", ctrl); bad++; end
    tick();
    mem_read_ex = 1'b0;
    #1; total++;
    if (ctrl !== 6'b110011) begin $display("FAIL lu_after ctrl=%b want=110011", ctrl); bad++; end
    total++;
    if (stall_cycles !== 4'd1) begin $display("FAIL lu_count stall=%0d want=1", stall_cycles); bad++; end
    tick();
    set_lu(5'd0, 5'd0, 1'b1);
    #1; total++;
    if (ctrl !== 6'b110011) begin $display("FAIL lu_rd0 ctrl=%b want=110011", ctrl); bad++; end
    tick();
    set_lu(5'd5, 5'd5, 1'b0);
    #1; total++;
    if (ctrl !== 6'b110011) begin $display("FAIL lu_unused ctrl=%b want=110011", ctrl); bad++; end
    tick();
    total++;
    if (stall_cycles !== 4'd1) begin $display("FAIL lu_count2 stall=%0d want=1", stall_cycles); bad++; end
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_lu(5'd7, 5'd7, 1'b1);
    branch_taken_ex = 1'b1;
    #1; total++;
    if (ctrl !== 6'b111111) begin $display("FAIL br_lu ctrl=%b want=111111", ctrl); bad++; end
    tick();
    total++;
    if (stall_cycles !== 4'd0) begin $display("FAIL br_lu_count stall=%0d want=0", stall_cycles); bad++; end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if (ctrl !== 6'b000000 || mem_wait !== (i > 0)) begin
        $display("FAIL memw_freeze%0d ctrl=%b wait=%b want ctrl=000000 wait=%0d", i, ctrl, mem_wait, i > 0);
        bad++;
      end
      tick();
    end
    mem_ready = 1'b1;
    #1; total++;
    if (ctrl !== 6'b110011 || mem_wait !== 1'b1) begin
      $display("FAIL memw_release ctrl=%b wait=%b want ctrl=110011 wait=1", ctrl, mem_wait); bad++;
    end
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    #1; total++;
    if (mem_wait !== 1'b0 || stall_cycles !== 4'd3) begin
      $display("FAIL memw_after wait=%b stall=%0d want wait=0 stall=3", mem_wait, stall_cycles); bad++;
    end
    mem_req = 1'b1; mem_ready = 1'b1;
    #1; total++;
    if (ctrl !== 6'b110011) begin $display("FAIL memw_same ctrl=%b want=110011", ctrl); bad++; end
    tick();
    idle_in();
    #1; total++;
    if (mem_wait !== 1'b0 || stall_cycles !== 4'd3) begin
      $display("FAIL memw_same_after wait=%b stall=%0d want wait=0 stall=3", mem_wait, stall_cycles); bad++;
    end
  endtask

  task automatic test_mem_branch();
    do_reset();
    branch_taken_ex = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; total++;
      if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b0 || pc_write !== 1'b0) begin
        $display("FAIL membr_frozen%0d ctrl=%b want=000000", i, ctrl); bad++;
      end
      tick();
    end
    mem_ready = 1'b1;
    #1; total++;
    if (ctrl !== 6'b111111) begin $display("FAIL membr_release ctrl=%b want=111111", ctrl); bad++; end
    tick();
    idle_in();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; total++;
      if (mem_timeout !== (i == 5)) begin
        $display("FAIL timeout_c%0d act=%b want=%0d", i, mem_timeout, i == 5); bad++;
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    idle_in();
    tick(); tick();
    total++;
    if (mem_timeout !== 1'b1 || mem_wait !== 1'b0) begin
      $display("FAIL timeout_sticky to=%b wait=%b want to=1 wait=0", mem_timeout, mem_wait); bad++;
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (7) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1; total++;
    if (mem_wait !== 1'b0 || stall_cycles !== 4'd0 || mem_timeout !== 1'b0) begin
      $display("FAIL rst_mid wait=%b stall=%0d to=%b want 0 0 0", mem_wait, stall_cycles, mem_timeout); bad++;
    end
    @(negedge clk);
    idle_in();
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    set_lu(5'd3, 5'd3, 1'b1);
    repeat (20) tick();
    idle_in();
    #1; total++;
    if (stall_cycles !== 4'd15) begin $display("FAIL sat stall=%0d want=15", stall_cycles); bad++; end
  endtask

  task automatic test_random();
    logic [5:0] e;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3));
      rs1_used = 1'($urandom); rs2_used = 1'($urandom); mem_read_ex = 1'($urandom);
      branch_taken_ex = ($urandom_range(0, 5) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      #1;
      e = exp_ctrl();
      total++;
      if (ctrl !== e || mem_wait !== m_wait || mem_timeout !== m_to || int'(stall_cycles) != m_stall) begin
        $display("FAIL rand%0d ctrl=%b wait=%b to=%b stall=%0d want ctrl=%b wait=%b to=%b stall=%0d",
                 n, ctrl, mem_wait, mem_timeout, stall_cycles, e, m_wait, m_to, m_stall);
        bad++;
      end
      tick();
      if (n % 150 == 149) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_mem_branch();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
